tlk2711_tx_sched: RTL and testbench
===================================

TLK2711_TX_SCHED -- requirements
Module: tlk2711_tx_sched

Interface
REQ-001 SHALL: clk  in  1  single clock for all logic.
REQ-002 SHALL: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: i_enable  in  1  link enable; sampled only in IDLE.
REQ-004 SHALL: i_stop  in  1  level request to park the link after the current frame.
REQ-005 SHALL: o_stop_ack  out  1  high while parked in STOPPED.
REQ-006 SHALL: i_req  in  2  per-channel frame request; held by the requester until its grant.
REQ-007 SHALL: i_len0, i_len1  in  8  payload length; value N means N+1 words; latched at grant.
REQ-008 SHALL: o_gnt  out  2  one-hot, single-cycle grant pulse.
REQ-009 SHALL: i_data0, i_data1  in  16  payload words.
REQ-010 SHALL: i_valid  in  2; o_ready  out  2  per-channel valid/ready payload handshake.
REQ-011 SHALL: o_txd  out  16; o_tkmsb, o_tklsb  out  1  TLK2711 transmit bus.
REQ-012 SHALL: o_enable  out  1  TLK2711 ENABLE; o_busy  out  1  frame in progress.
REQ-013 SHALL: o_frame_cnt  out  16  count of completed frames.

Function
REQ-014 SHALL: FSM states are IDLE, SOF, HDR, DATA, EOF, GAP, STOPPED.
REQ-015 SHALL: all outputs are registered; the word for state S appears on o_txd/o_tk* the cycle after the FSM is in S.
REQ-016 SHALL: IDLE, GAP and STOPPED emit the idle word {D5_6,K28_5}, tkmsb=0, tklsb=1.
REQ-017 SHALL: SOF emits {D11_5,K28_5}, tklsb=1; EOF emits {D21_5,K28_5}, tklsb=1.
REQ-018 SHALL: HDR emits {7'b0, ch, len}, tkmsb=tklsb=0.
REQ-019 SHALL: IDLE -> SOF when i_enable=1, i_stop=0 and any i_req=1; the o_gnt bit for the winner pulses in the same cycle as entry to SOF.
REQ-020 SHALL: arbitration is round-robin; if both channels request, the channel not granted last wins; after reset ch0 wins.
REQ-021 SHALL: SOF -> HDR -> DATA unconditionally, one cycle each.
REQ-022 SHALL: in DATA, o_ready is high only for the granted channel; a word transfers on valid&ready and is emitted with tk=00.
REQ-023 SHALL: in DATA with valid=0, an idle word is emitted (underflow filler) and the remaining count is unchanged.
REQ-024 SHALL: the transfer of the (len+1)-th word moves DATA -> EOF; o_ready drops in the following cycle.
REQ-025 SHALL: EOF -> GAP; GAP lasts exactly 2 cycles, then goes to STOPPED if i_stop=1, else to IDLE.
REQ-026 SHALL: o_frame_cnt increments in EOF and wraps 0xFFFF -> 0x0000.
REQ-027 SHALL: i_stop asserted mid-frame does not truncate the frame; the frame completes through EOF and GAP.
REQ-028 SHALL: IDLE with i_stop=1 goes to STOPPED in the next cycle; i_stop has priority over a simultaneous i_req.
REQ-029 SHALL: STOPPED -> IDLE when i_stop=0; o_stop_ack follows the STOPPED state with one-cycle latency.
REQ-030 SHALL: o_enable=1 whenever the FSM is not in IDLE with i_enable=0; o_busy=1 in SOF through EOF.
REQ-031 SHALL: i_len and i_req changes after grant have no effect on the current frame.

Reset
REQ-032 SHALL: on reset, o_txd=0, o_tkmsb=0, o_tklsb=0, o_enable=0, o_gnt=0, o_ready=0, o_stop_ack=0, o_busy=0, o_frame_cnt=0, FSM=IDLE, round-robin pointer favours ch0.
REQ-033 SHALL: reset asserted mid-frame abandons the frame immediately; no EOF is emitted.

Structure
REQ-034 SHALL: K28_5=8'hBC, D5_6=8'hC5, D11_5=8'hAB, D21_5=8'hB5 and the FSM state enum live in shared package tlk2711_pkg.
REQ-035 SHALL: the round-robin arbiter is sub-module tlk2711_rr_arb (2 requesters, registered last-grant pointer).

Verification
REQ-036 SHALL: i_req=01, i_len0=2, valid held high -> words SOF, HDR 0x0002, 3 data words, EOF, 2 idle words; o_frame_cnt=1.
REQ-037 SHALL: i_req=11 continuously, both lengths 0 -> grants alternate ch0, ch1, ch0, ...; HDR bit 8 alternates 0, 1, 0.
REQ-038 SHALL: ch1 valid low for 3 cycles mid-payload -> 3 idle filler words are emitted and the payload count is still exact.
REQ-039 SHALL: i_stop raised during DATA of a 10-word frame -> the full frame and EOF complete, then GAP, then o_stop_ack=1; i_stop=0 -> back to IDLE.
REQ-040 SHALL: rst_n pulsed low during DATA -> all outputs return to reset values asynchronously; the next frame starts with ch0 priority.
REQ-041 SHALL: preload o_frame_cnt to 0xFFFF via 65535 single-word frames (or force) -> the next EOF yields 0x0000.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared constants, FSM state type and small helpers for the TLK2711 transmit scheduler.
package tlk2711_pkg;

    // 8b/10b code points used to build the 16-bit control words.
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D11_5 = 8'hAB;
    localparam logic [7:0] D21_5 = 8'hB5;

    // Control words: comma in the low byte, framing code in the high byte.
    localparam logic [15:0] IDLE_WORD = {D5_6,  K28_5};
    localparam logic [15:0] SOF_WORD  = {D11_5, K28_5};
    localparam logic [15:0] EOF_WORD  = {D21_5, K28_5};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_HDR     = 3'd2,
        ST_DATA    = 3'd3,
        ST_EOF     = 3'd4,
        ST_GAP     = 3'd5,
        ST_STOPPED = 3'd6
    } state_t;

    // Channel index to one-hot request/grant vector.
    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tlk2711_rr_arb.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner.
module tlk2711_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_ch
);

    // Last granted channel; reset to 1 so that ch0 wins the first contention.
    logic last_q;
    logic last_d;

    // Pick the winner: a lone requester wins, on contention the one not granted last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        gnt_ch = gnt[1];
    end

    // Move the pointer only when the grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tlk2711_tx_sched.sv
// Frames payload from two channels onto the TLK2711 16-bit transmit bus.
// Every output is a flop; the word for FSM state S is visible one cycle later.
module tlk2711_tx_sched
    import tlk2711_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic        i_stop,
    output logic        o_stop_ack,
    input  logic [1:0]  i_req,
    input  logic [7:0]  i_len0,
    input  logic [7:0]  i_len1,
    output logic [1:0]  o_gnt,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    input  logic [1:0]  i_valid,
    output logic [1:0]  o_ready,
    output logic [15:0] o_txd,
    output logic        o_tkmsb,
    output logic        o_tklsb,
    output logic        o_enable,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    state_t      state_q,     state_d;
    logic        ch_q,        ch_d;
    logic [7:0]  len_q,       len_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        gap_q,       gap_d;
    logic [15:0] txd_q,       txd_d;
    logic        tkmsb_q,     tkmsb_d;
    logic        tklsb_q,     tklsb_d;
    logic [1:0]  gnt_q,       gnt_d;
    logic [1:0]  ready_q,     ready_d;
    logic        stop_ack_q,  stop_ack_d;
    logic        enable_q,    enable_d;
    logic        busy_q,      busy_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [1:0]  arb_gnt_s;
    logic        arb_ch_s;
    logic        start_s;
    logic        xfer_s;
    logic [15:0] data_s;

    // A frame may start only from IDLE, with the link enabled and no stop pending.
    assign start_s = (state_q == ST_IDLE) && !i_stop && i_enable && (i_req != 2'b00);
    assign xfer_s  = (state_q == ST_DATA) && ready_q[ch_q] && i_valid[ch_q];
    assign data_s  = ch_q ? i_data1 : i_data0;

    tlk2711_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (i_req),
        .advance (start_s),
        .gnt     (arb_gnt_s),
        .gnt_ch  (arb_ch_s)
    );

    // Next-state logic and the word to emit for the current state.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        gnt_d       = 2'b00;
        txd_d       = IDLE_WORD;
        tkmsb_d     = 1'b0;
        tklsb_d     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (i_stop) begin
                    state_d = ST_STOPPED;
                end else if (start_s) begin
                    state_d = ST_SOF;
                    ch_d    = arb_ch_s;
                    len_d   = arb_ch_s ? i_len1 : i_len0;
                    cnt_d   = arb_ch_s ? i_len1 : i_len0;
                    gnt_d   = arb_gnt_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SOF: begin
                txd_d   = SOF_WORD;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                txd_d   = {7'b000_0000, ch_q, len_q};
                tklsb_d = 1'b0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                // No valid word: keep the idle filler and hold the remaining count.
                if (xfer_s) begin
                    txd_d   = data_s;
                    tklsb_d = 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_EOF;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    txd_d = IDLE_WORD;
                end
            end
            ST_EOF: begin
                txd_d       = EOF_WORD;
                frame_cnt_d = frame_cnt_q + 16'd1;
                gap_d       = 1'b0;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q) begin
                    state_d = i_stop ? ST_STOPPED : ST_IDLE;
                    gap_d   = 1'b0;
                end else begin
                    gap_d = 1'b1;
                end
            end
            ST_STOPPED: begin
                if (!i_stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs derived from the current/next state.
    always_comb begin
        if (state_d == ST_DATA) begin
            ready_d = ch_onehot(ch_d);
        end else begin
            ready_d = 2'b00;
        end
        stop_ack_d = (state_q == ST_STOPPED);
        enable_d   = !((state_q == ST_IDLE) && !i_enable);
        busy_d     = (state_q == ST_SOF) || (state_q == ST_HDR) ||
                     (state_q == ST_DATA) || (state_q == ST_EOF);
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= 1'b0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            gap_q       <= 1'b0;
            txd_q       <= 16'd0;
            tkmsb_q     <= 1'b0;
            tklsb_q     <= 1'b0;
            gnt_q       <= 2'b00;
            ready_q     <= 2'b00;
            stop_ack_q  <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            txd_q       <= txd_d;
            tkmsb_q     <= tkmsb_d;
            tklsb_q     <= tklsb_d;
            gnt_q       <= gnt_d;
            ready_q     <= ready_d;
            stop_ack_q  <= stop_ack_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_txd       = txd_q;
    assign o_tkmsb     = tkmsb_q;
    assign o_tklsb     = tklsb_q;
    assign o_gnt       = gnt_q;
    assign o_ready     = ready_q;
    assign o_stop_ack  = stop_ack_q;
    assign o_enable    = enable_q;
    assign o_busy      = busy_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// Scoreboard bench for tlk2711_tx_sched: the driver pushes expected frame words
// and grants into queues; a monitor pops and compares every non-idle bus word.
module tb_tlk2711_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable, i_stop, o_stop_ack;
    logic [1:0]  i_req, o_gnt, i_valid, o_ready;
    logic [7:0]  i_len0, i_len1;
    logic [15:0] i_data0, i_data1, o_txd, o_frame_cnt;
    logic        o_tkmsb, o_tklsb, o_enable, o_busy;

    tlk2711_tx_sched dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_stop(i_stop),
        .o_stop_ack(o_stop_ack), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
        .o_gnt(o_gnt), .i_data0(i_data0), .i_data1(i_data1), .i_valid(i_valid),
        .o_ready(o_ready), .o_txd(o_txd), .o_tkmsb(o_tkmsb), .o_tklsb(o_tklsb),
        .o_enable(o_enable), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    // Bus words as {tkmsb, tklsb, txd}.
    localparam logic [17:0] W_IDLE = {2'b01, 16'hC5BC};
    localparam logic [17:0] W_SOF  = {2'b01, 16'hABBC};
    localparam logic [17:0] W_EOF  = {2'b01, 16'hB5BC};

    logic [17:0] exp_q[$];
    logic [1:0]  gnt_exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          eof_cyc = -1;
    bit          mon_en = 1'b0;
    bit          chk_gap = 1'b0;
    logic        last_ch;       // reference round-robin memory: channel granted last
    logic [15:0] model_cnt;     // reference completed-frame count

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: grants and non-idle bus words are compared against the queues.
    initial forever begin
        logic [17:0] w;
        logic [17:0] e;
        @(negedge clk);
        if (mon_en && rst_n) begin
            if (o_gnt != 2'b00) begin
                if (gnt_exp_q.size() == 0) check("gnt_unexpected", {30'd0, o_gnt}, 32'd0);
                else check("gnt", {30'd0, o_gnt}, {30'd0, gnt_exp_q.pop_front()});
            end
            w = {o_tkmsb, o_tklsb, o_txd};
            if (w != W_IDLE) begin
                if (exp_q.size() == 0) begin
                    check("word_unexpected", {14'd0, w}, {14'd0, W_IDLE});
                end else begin
                    e = exp_q.pop_front();
                    check("word", {14'd0, w}, {14'd0, e});
                    if (e == W_SOF && chk_gap && eof_cyc >= 0) check("eof_to_sof_gap", cyc - eof_cyc, 32'd4);
                    if (e == W_EOF) eof_cyc = cyc;
                end
            end
        end
    end

    // Expected sequence of one frame for channel w.
    task automatic push_frame(input logic w, input logic [7:0] len, input logic [15:0] pl[$]);
        gnt_exp_q.push_back(w ? 2'b10 : 2'b01);
        exp_q.push_back(W_SOF);
        exp_q.push_back({2'b00, 7'd0, w, len});
        foreach (pl[i]) exp_q.push_back({2'b00, pl[i]});
        exp_q.push_back(W_EOF);
        model_cnt = model_cnt + 16'd1;
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) check({name, "_drain_timeout"}, exp_q.size(), 32'd0);
        @(negedge clk);
        check({name, "_frame_cnt"}, {16'd0, o_frame_cnt}, {16'd0, model_cnt});
    endtask

    task automatic reset_mid_frame();
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_outputs",
              {8'd0, o_txd, o_tkmsb, o_tklsb, o_gnt, o_ready, o_stop_ack, o_enable, o_busy},
              32'd0);
        check("reset_async_frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
        exp_q.delete();
        gnt_exp_q.delete();
        last_ch = 1'b1;
        model_cnt = 16'd0;
        i_req = 2'b00; i_valid = 2'b00; i_stop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // One frame with randomly gapped valid on the winning channel.
    task automatic run_frame(input logic [1:0] req, input logic [7:0] l0, input logic [7:0] l1,
                             input bit stop_mid, input bit rst_mid);
        logic        w;
        logic [7:0]  len;
        logic [15:0] pl[$];
        int          idx, k;
        bit          got, vld;
        w = (req == 2'b11) ? ~last_ch : req[1];
        last_ch = w;
        len = w ? l1 : l0;
        for (int i = 0; i <= int'(len); i++) pl.push_back(16'($urandom));
        push_frame(w, len, pl);
        @(negedge clk);
        i_enable = 1'b1; i_req = req; i_len0 = l0; i_len1 = l1;
        got = 1'b0;
        for (k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (o_gnt != 2'b00) got = 1'b1;
        end
        if (!got) begin
            check("grant_timeout", 32'd0, 32'd1);
            return;
        end
        // Request and length changes after the grant must not disturb the frame.
        i_req = 2'b00; i_len0 = 8'($urandom); i_len1 = 8'($urandom);
        idx = 0;
        for (k = 0; k < 600 && idx <= int'(len); k++) begin
            @(negedge clk);
            vld = ($urandom % 4) != 0;
            i_valid[w]  = vld;
            i_valid[~w] = 1'($urandom);
            if (w) begin i_data1 = pl[idx]; i_data0 = 16'($urandom); end
            else   begin i_data0 = pl[idx]; i_data1 = 16'($urandom); end
            if (vld && o_ready[w]) idx++;
            if (stop_mid && idx == 3) i_stop = 1'b1;
            if (rst_mid && idx == 2) begin
                reset_mid_frame();
                return;
            end
        end
        if (idx <= int'(len)) check("payload_timeout", idx, {24'd0, len} + 32'd1);
        @(negedge clk);
        i_valid = 2'b00;
        wait_drain("frame");
    endtask

    // Continuous contention with zero-length frames: grants must alternate.
    task automatic b2b(input int n);
        logic [15:0] d0, d1;
        logic [15:0] pl[$];
        logic        w;
        int          g, k;
        d0 = 16'($urandom); d1 = 16'($urandom);
        chk_gap = 1'b1; eof_cyc = -1;
        for (int i = 0; i < n; i++) begin
            w = ~last_ch; last_ch = w;
            pl.delete();
            pl.push_back(w ? d1 : d0);
            push_frame(w, 8'd0, pl);
        end
        @(negedge clk);
        i_len0 = 8'd0; i_len1 = 8'd0; i_data0 = d0; i_data1 = d1;
        i_valid = 2'b11; i_req = 2'b11; i_enable = 1'b1;
        g = 0;
        for (k = 0; k < 400 && g < n; k++) begin
            @(negedge clk);
            if (o_gnt != 2'b00) g++;
        end
        i_req = 2'b00;
        if (g < n) check("b2b_grant_timeout", g, n);
        wait_drain("b2b");
        i_valid = 2'b00;
        chk_gap = 1'b0;
    endtask

    initial begin
        int k, j;
        rst_n = 1'b0; i_enable = 1'b0; i_stop = 1'b0; i_req = 2'b00; i_valid = 2'b00;
        i_len0 = 8'd0; i_len1 = 8'd0; i_data0 = 16'd0; i_data1 = 16'd0;
        last_ch = 1'b1; model_cnt = 16'd0;
        #12;
        check("reset_outputs",
              {8'd0, o_txd, o_tkmsb, o_tklsb, o_gnt, o_ready, o_stop_ack, o_enable, o_busy}, 32'd0);
        check("reset_frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("enable_low_when_idle_disabled", {31'd0, o_enable}, 32'd0);
        mon_en = 1'b1;

        // Single ch0 frame of three words.
        run_frame(2'b01, 8'd2, 8'd0, 1'b0, 1'b0);
        check("enable_high", {31'd0, o_enable}, 32'd1);

        // Alternating grants under continuous contention.
        b2b(6);

        // Randomised frames, requests and lengths.
        for (int i = 0; i < 20; i++)
            run_frame(2'($urandom_range(1, 3)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b0, 1'b0);

        // Stop raised mid-frame on a 10-word frame.
        run_frame(2'b10, 8'd0, 8'd9, 1'b1, 1'b0);
        for (k = 0; k < 20; k++) begin
            if (o_stop_ack) break;
            @(negedge clk);
        end
        check("stop_ack_after_frame", {31'd0, o_stop_ack}, 32'd1);
        check("eof_to_stop_ack", cyc - eof_cyc, 32'd3);
        i_req = 2'b11;
        repeat (5) @(negedge clk);
        check("stopped_holds", {31'd0, o_stop_ack}, 32'd1);
        i_req = 2'b00;
        @(negedge clk);
        i_stop = 1'b0;
        @(negedge clk); @(negedge clk);
        check("stop_release", {31'd0, o_stop_ack}, 32'd0);
        repeat (2) @(negedge clk);

        // Stop from IDLE beats a simultaneous request.
        i_stop = 1'b1; i_req = 2'b01;
        j = cyc;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_stop_ack) break;
        end
        check("idle_stop_latency", cyc - j, 32'd2);
        i_req = 2'b00;
        @(negedge clk);
        i_stop = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-payload, then ch0 must win contention again.
        run_frame(2'b01, 8'd8, 8'd0, 1'b0, 1'b1);
        run_frame(2'b11, 8'd1, 8'd1, 1'b0, 1'b0);

        // Frame counter wrap.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        model_cnt = 16'hFFFF;
        check("frame_cnt_preload", {16'd0, o_frame_cnt}, 32'h0000FFFF);
        run_frame(2'b01, 8'd0, 8'd0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("gnt_queue_empty", gnt_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
